// File: rtl/apogeo_pkg.sv
// Shared types and sizing constants for the reorder buffer slice.
package apogeo_pkg;

   localparam int ROB_DEPTH = 64;
   localparam int ROB_TAG_W = 6;

   typedef logic [31:0] data_word_t;

   typedef struct packed {
      data_word_t result;
      logic [4:0] reg_dest;
      logic       exception;
      logic [4:0] exception_vector;
   } rob_entry_t;

endpackage

// File: rtl/rob_memory.sv
// Entry storage for the reorder buffer: one synchronous write port,
// one asynchronous read port addressed by the head pointer.
module rob_memory
   import apogeo_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ROB_TAG_W-1:0] wr_addr,
   input  rob_entry_t           wr_data,
   input  logic [ROB_TAG_W-1:0] rd_addr,
   output rob_entry_t           rd_data
);

   rob_entry_t mem [DEPTH];

   // Store a result at its tag; storage carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: hands out tags at dispatch, accepts
// out-of-order results and retires them in tag order to writeback.
// Optional macro ROB_BYPASS_EN: a result written to the empty head slot
// retires in the same cycle instead of one cycle later.
// Optional macro TEST_DESIGN: checks that writes target allocated tags.
module reorder_buffer
   import apogeo_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 stall_i,
   input  logic                 alloc_i,
   output logic [ROB_TAG_W-1:0] alloc_tag_o,
   output logic                 full_o,
   output logic                 empty_o,
   input  logic                 write_i,
   input  logic [ROB_TAG_W-1:0] write_tag_i,
   input  rob_entry_t           entry_i,
   output logic                 retire_o,
   output logic [ROB_TAG_W-1:0] retire_tag_o,
   output logic                 wb_write_o,
   output logic [4:0]           wb_reg_o,
   output data_word_t           wb_data_o,
   output logic                 exception_o,
   output logic [4:0]           exception_vector_o
);

   localparam logic [ROB_TAG_W:0] FULL_COUNT = (ROB_TAG_W+1)'(DEPTH);

   logic [ROB_TAG_W-1:0] head;
   logic [ROB_TAG_W-1:0] tail;
   logic [ROB_TAG_W:0]   count;
   logic [DEPTH-1:0]     valid;
   rob_entry_t           head_entry;
   rob_entry_t           retire_entry;
   logic                 bypass_hit;

   rob_memory #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk_i),
      .wr_en   (write_i),
      .wr_addr (write_tag_i),
      .wr_data (entry_i),
      .rd_addr (head),
      .rd_data (head_entry)
   );

`ifdef ROB_BYPASS_EN
   assign bypass_hit = write_i && (write_tag_i == head) && !valid[head];
`else
   assign bypass_hit = 1'b0;
`endif

   // Retire path is combinational from head state (or the bypassed write).
   assign retire_entry       = bypass_hit ? entry_i : head_entry;
   assign retire_o           = (valid[head] || bypass_hit) && !stall_i && !flush_i;
   assign retire_tag_o       = retire_o ? head : '0;
   assign wb_write_o         = retire_o && !retire_entry.exception;
   assign wb_reg_o           = retire_o ? retire_entry.reg_dest : '0;
   assign wb_data_o          = retire_o ? retire_entry.result : '0;
   assign exception_o        = retire_o && retire_entry.exception;
   assign exception_vector_o = exception_o ? retire_entry.exception_vector : '0;

   // Status comes from the registered count, so a same-cycle retire
   // never frees a slot for allocation.
   assign alloc_tag_o = tail;
   assign full_o      = (count == FULL_COUNT);
   assign empty_o     = (count == '0);

   // Pointer, occupancy and valid-bit bookkeeping; flush and reset win.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (alloc_i) begin
            tail        <= tail + 1'b1;
            valid[tail] <= 1'b0;
         end
         if (retire_o) begin
            head        <= head + 1'b1;
            valid[head] <= 1'b0;
         end
         // A bypassed entry leaves straight away and never becomes valid.
         if (write_i && !(bypass_hit && retire_o))
            valid[write_tag_i] <= 1'b1;
         unique case ({alloc_i, retire_o})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef TEST_DESIGN
   logic [ROB_TAG_W-1:0] write_offset;
   assign write_offset = write_tag_i - head;

   // A write must land inside the allocated window [head, head+count).
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && write_i)
         assert ({1'b0, write_offset} < count)
         else $error("reorder_buffer: write to unallocated tag %0d", write_tag_i);
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; expectations follow
// the build configuration (ROB_BYPASS_EN defined or not).
module tb_reorder_buffer;
   import apogeo_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i, flush_i, stall_i, alloc_i, write_i;
   logic [5:0] write_tag_i;
   rob_entry_t entry_i;
   logic [5:0] alloc_tag_o, retire_tag_o;
   logic       full_o, empty_o, retire_o, wb_write_o, exception_o;
   logic [4:0] wb_reg_o, exception_vector_o;
   data_word_t wb_data_o;

   int total = 0;
   int bad   = 0;

   reorder_buffer #(.DEPTH(64)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .stall_i            (stall_i),
      .alloc_i            (alloc_i),
      .alloc_tag_o        (alloc_tag_o),
      .full_o             (full_o),
      .empty_o            (empty_o),
      .write_i            (write_i),
      .write_tag_i        (write_tag_i),
      .entry_i            (entry_i),
      .retire_o           (retire_o),
      .retire_tag_o       (retire_tag_o),
      .wb_write_o         (wb_write_o),
      .wb_reg_o           (wb_reg_o),
      .wb_data_o          (wb_data_o),
      .exception_o        (exception_o),
      .exception_vector_o (exception_vector_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic clear_inputs();
      flush_i = 1'b0; stall_i = 1'b0; alloc_i = 1'b0;
      write_i = 1'b0; write_tag_i = '0; entry_i = '0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic drive_write(input logic [5:0] tag, input logic [31:0] data,
                              input logic [4:0] rd, input logic exc, input logic [4:0] vec);
      write_i                = 1'b1;
      write_tag_i            = tag;
      entry_i.result           = data;
      entry_i.reg_dest         = rd;
      entry_i.exception        = exc;
      entry_i.exception_vector = vec;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (alloc_tag_o !== 6'd0) begin bad++; $display("FAIL reset_alloc_tag got=%0d want=0", alloc_tag_o); end
      total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_o); end
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_o); end
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL reset_retire got=%b want=0", retire_o); end
      total++; if (wb_write_o !== 1'b0) begin bad++; $display("FAIL reset_wb_write got=%b want=0", wb_write_o); end
      total++; if (exception_o !== 1'b0) begin bad++; $display("FAIL reset_exception got=%b want=0", exception_o); end
   endtask

   task automatic test_in_order();
      logic [5:0]  wtag [3];
      logic [31:0] wdat [3];
      logic        exp_ret [6];
      logic [5:0]  exp_tag [6];
      logic [31:0] exp_dat [6];
      wtag = '{6'd2, 6'd0, 6'd1};
      wdat = '{32'hC, 32'hA, 32'hB};
`ifdef ROB_BYPASS_EN
      exp_ret = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_tag = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd0, 6'd0};
      exp_dat = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0, 32'h0};
`else
      exp_ret = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_tag = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd0};
      exp_dat = '{32'h0, 32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
`endif
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alloc_i = 1'b1;
         #1;
         total++; if (alloc_tag_o !== 6'(i)) begin bad++; $display("FAIL order_alloc_tag got=%0d want=%0d", alloc_tag_o, i); end
         tick();
      end
      alloc_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c < 3) drive_write(wtag[c], wdat[c], 5'd1, 1'b0, 5'd0);
         else write_i = 1'b0;
         #1;
         total++; if (retire_o !== exp_ret[c]) begin bad++; $display("FAIL order_retire cycle=%0d got=%b want=%b", c, retire_o, exp_ret[c]); end
         if (exp_ret[c]) begin
            total++; if (retire_tag_o !== exp_tag[c]) begin bad++; $display("FAIL order_tag cycle=%0d got=%0d want=%0d", c, retire_tag_o, exp_tag[c]); end
            total++; if (wb_data_o !== exp_dat[c]) begin bad++; $display("FAIL order_data cycle=%0d got=%0h want=%0h", c, wb_data_o, exp_dat[c]); end
            total++; if (wb_write_o !== 1'b1) begin bad++; $display("FAIL order_wb_write cycle=%0d got=%b want=1", c, wb_write_o); end
         end
         tick();
      end
      #1;
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL order_empty got=%b want=1", empty_o); end
   endtask

   task automatic test_full_wrap();
      int next_tag;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         alloc_i = 1'b1;
         #1;
         total++; if (alloc_tag_o !== 6'(i)) begin bad++; $display("FAIL fill_alloc_tag got=%0d want=%0d", alloc_tag_o, i); end
         tick();
      end
      alloc_i = 1'b0;
      #1;
      total++; if (full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full_o); end
      total++; if (alloc_tag_o !== 6'd0) begin bad++; $display("FAIL fill_tail_wrap got=%0d want=0", alloc_tag_o); end
      total++; if (empty_o !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b want=0", empty_o); end
      next_tag = 0;
      for (int i = 0; i < 70; i++) begin
         if (i < 64) drive_write(6'(i), 32'h100 + i, 5'(i), 1'b0, 5'd0);
         else write_i = 1'b0;
         #1;
         if (retire_o) begin
            total++; if (retire_tag_o !== 6'(next_tag)) begin bad++; $display("FAIL drain_tag got=%0d want=%0d", retire_tag_o, next_tag); end
            total++; if (wb_data_o !== 32'h100 + next_tag) begin bad++; $display("FAIL drain_data got=%0h want=%0h", wb_data_o, 32'h100 + next_tag); end
            next_tag++;
         end
         tick();
      end
      #1;
      total++; if (next_tag !== 64) begin bad++; $display("FAIL drain_count got=%0d want=64", next_tag); end
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty_o); end
      total++; if (full_o !== 1'b0) begin bad++; $display("FAIL drain_full got=%b want=0", full_o); end
      total++; if (alloc_tag_o !== 6'd0) begin bad++; $display("FAIL drain_alloc_tag got=%0d want=0", alloc_tag_o); end
   endtask

   task automatic test_exception();
      do_reset();
      alloc_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      alloc_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_write(6'(i), 32'(i), 5'd1, 1'b0, 5'd0);
         tick();
      end
      write_i = 1'b0;
      tick();
      tick();
      total++; if (empty_o !== 1'b0) begin bad++; $display("FAIL exc_pending_empty got=%b want=0", empty_o); end
      drive_write(6'd5, 32'hDEAD, 5'd9, 1'b1, 5'h0B);
`ifndef ROB_BYPASS_EN
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL exc_early_retire got=%b want=0", retire_o); end
      tick();
      write_i = 1'b0;
`endif
      #1;
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL exc_retire got=%b want=1", retire_o); end
      total++; if (retire_tag_o !== 6'd5) begin bad++; $display("FAIL exc_tag got=%0d want=5", retire_tag_o); end
      total++; if (exception_o !== 1'b1) begin bad++; $display("FAIL exc_flag got=%b want=1", exception_o); end
      total++; if (exception_vector_o !== 5'h0B) begin bad++; $display("FAIL exc_vector got=%0h want=b", exception_vector_o); end
      total++; if (wb_write_o !== 1'b0) begin bad++; $display("FAIL exc_wb_write got=%b want=0", wb_write_o); end
      tick();
      write_i = 1'b0;
      #1;
      total++; if (alloc_tag_o !== 6'd6) begin bad++; $display("FAIL exc_pre_flush_tag got=%0d want=6", alloc_tag_o); end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL exc_flush_empty got=%b want=1", empty_o); end
      total++; if (alloc_tag_o !== 6'd0) begin bad++; $display("FAIL exc_flush_tag got=%0d want=0", alloc_tag_o); end
   endtask

   task automatic test_stall();
      do_reset();
      alloc_i = 1'b1;
      tick();
      alloc_i = 1'b0;
      stall_i = 1'b1;
      drive_write(6'd0, 32'h1234, 5'd7, 1'b0, 5'd0);
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL stall_write_cycle got=%b want=0", retire_o); end
      tick();
      write_i = 1'b0;
      for (int s = 0; s < 4; s++) begin
         #1;
         total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL stall_retire cycle=%0d got=%b want=0", s, retire_o); end
         total++; if (wb_write_o !== 1'b0) begin bad++; $display("FAIL stall_wb_write cycle=%0d got=%b want=0", s, wb_write_o); end
         tick();
      end
      stall_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL stall_release_retire got=%b want=1", retire_o); end
      total++; if (wb_write_o !== 1'b1) begin bad++; $display("FAIL stall_release_wb got=%b want=1", wb_write_o); end
      total++; if (wb_reg_o !== 5'd7) begin bad++; $display("FAIL stall_release_reg got=%0d want=7", wb_reg_o); end
      total++; if (wb_data_o !== 32'h1234) begin bad++; $display("FAIL stall_release_data got=%0h want=1234", wb_data_o); end
      tick();
      #1;
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL stall_after_empty got=%b want=1", empty_o); end
   endtask

   task automatic test_flush_same_cycle();
      do_reset();
      alloc_i = 1'b1;
      tick();
      tick();
      alloc_i = 1'b0;
      stall_i = 1'b1;
      drive_write(6'd0, 32'h77, 5'd2, 1'b0, 5'd0);
      tick();
      write_i = 1'b0;
      stall_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL flush_head_ready got=%b want=1", retire_o); end
      alloc_i = 1'b1;
      flush_i = 1'b1;
      drive_write(6'd1, 32'h88, 5'd3, 1'b0, 5'd0);
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL flush_retire got=%b want=0", retire_o); end
      tick();
      clear_inputs();
      #1;
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", empty_o); end
      total++; if (alloc_tag_o !== 6'd0) begin bad++; $display("FAIL flush_alloc_tag got=%0d want=0", alloc_tag_o); end
      total++; if (dut.count !== 7'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", dut.count); end
      total++; if (dut.valid !== 64'd0) begin bad++; $display("FAIL flush_valid got=%0h want=0", dut.valid); end
      alloc_i = 1'b1;
      tick();
      alloc_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL flush_stale_retire got=%b want=0", retire_o); end
      // Reset in the middle of operation discards the pending entry.
      stall_i = 1'b1;
      drive_write(6'd0, 32'h99, 5'd4, 1'b0, 5'd0);
      tick();
      write_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      stall_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL midreset_retire got=%b want=0", retire_o); end
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%b want=1", empty_o); end
   endtask

   task automatic test_bypass();
      do_reset();
      alloc_i = 1'b1;
      tick();
      alloc_i = 1'b0;
      drive_write(6'd0, 32'h55, 5'd3, 1'b0, 5'd0);
      #1;
`ifdef ROB_BYPASS_EN
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL bypass_retire got=%b want=1", retire_o); end
      total++; if (wb_reg_o !== 5'd3) begin bad++; $display("FAIL bypass_reg got=%0d want=3", wb_reg_o); end
      total++; if (wb_data_o !== 32'h55) begin bad++; $display("FAIL bypass_data got=%0h want=55", wb_data_o); end
      tick();
      write_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL bypass_no_repeat got=%b want=0", retire_o); end
`else
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", retire_o); end
      tick();
      write_i = 1'b0;
      #1;
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL latency_retire got=%b want=1", retire_o); end
      total++; if (wb_reg_o !== 5'd3) begin bad++; $display("FAIL latency_reg got=%0d want=3", wb_reg_o); end
      total++; if (wb_data_o !== 32'h55) begin bad++; $display("FAIL latency_data got=%0h want=55", wb_data_o); end
      tick();
      #1;
`endif
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL bypass_empty got=%b want=1", empty_o); end
   endtask

   initial begin
      rst_i = 1'b1;
      clear_inputs();
      test_reset();
      test_in_order();
      test_full_wrap();
      test_exception();
      test_stall();
      test_flush_same_cycle();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
